// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer alarm block.
//   TIMER_W : width of the upstream timer count and of the alarm threshold.
//   state_e : alarm FSM encoding. The 2-bit encoding is fully used, so no
//             illegal state exists.
package timer_alarm_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_sync.sv
// Samples the asynchronous ripple-timer count into the clk domain and filters
// out glitches.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   timer_time  : raw count from the ripple timer (may glitch)
//   stable_time : filtered, clk-synchronous copy of timer_time
//   tick        : one-cycle strobe, high in the cycle right after stable_time
//                 took a new value
module timer_sync
  import timer_alarm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [TIMER_W-1:0] timer_time,
  output logic [TIMER_W-1:0] stable_time,
  output logic               tick
);

  logic [TIMER_W-1:0] s1;
  logic [TIMER_W-1:0] s2;
  logic               agree;

  // A new value is accepted only once two consecutive samples agree, so a
  // count that is mid-ripple for a single sample never reaches stable_time.
  assign agree = (s1 == s2) && (s2 != stable_time);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1          <= '0;
      s2          <= '0;
      stable_time <= '0;
      tick        <= 1'b0;
    end else begin
      s1   <= timer_time;
      s2   <= s1;
      tick <= agree;
      if (agree) begin
        stable_time <= s2;
      end
    end
  end

endmodule

// File: rtl/timer_alarm.sv
// Alarm clock controller: compares the filtered timer count against a
// programmable threshold, rings, and supports a bounded number of snoozes.
//   clk, reset  : system clock (rising edge), asynchronous active-low reset
//   timer_time  : raw ripple-timer count (asynchronous, may glitch)
//   set_en      : load set_value into the threshold (honoured in IDLE only)
//   set_value   : alarm threshold
//   arm         : IDLE -> ARMED
//   ack         : dismiss the alarm (wins over snooze)
//   snooze      : postpone the alarm by SNOOZE_TICKS timer increments
//   stable_time : filtered copy of timer_time
//   alarm       : high while RINGING
//   alarm_pulse : one-cycle strobe on every entry to RINGING
//   state       : FSM state (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)
//   snooze_cnt  : snoozes used in the current alarm event
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int SNOOZE_TICKS = 8,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TIMER_W-1:0] timer_time,
  input  logic               set_en,
  input  logic [TIMER_W-1:0] set_value,
  input  logic               arm,
  input  logic               ack,
  input  logic               snooze,
  output logic [TIMER_W-1:0] stable_time,
  output logic               alarm,
  output logic               alarm_pulse,
  output logic [1:0]         state,
  output logic [1:0]         snooze_cnt
);

  localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_TICKS);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

  state_e             state_q, next_state;
  logic [TIMER_W-1:0] thr_q, next_thr;
  logic [7:0]         down_q, next_down;
  logic [1:0]         snz_q, next_snz;
  logic               tick;

  timer_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .timer_time (timer_time),
    .stable_time(stable_time),
    .tick       (tick)
  );

  always_comb begin
    next_state = state_q;
    next_thr   = thr_q;
    next_down  = down_q;
    next_snz   = snz_q;
    case (state_q)
      IDLE: begin
        if (set_en) next_thr = set_value;
        if (arm)    next_state = ARMED;
      end
      ARMED: begin
        // Only a fresh tick can match; an equality that already held when
        // arming has to wait for the count to come round again.
        if (tick && (stable_time == thr_q)) next_state = RINGING;
      end
      RINGING: begin
        if (ack) begin
          next_state = IDLE;
        end else if (snooze && (snz_q < SNOOZE_MAX)) begin
          next_state = SNOOZE;
          next_down  = SNOOZE_LOAD;
          next_snz   = snz_q + 2'd1;
        end
      end
      SNOOZE: begin
        if (ack) begin
          next_state = IDLE;
        end else if (tick) begin
          next_down = down_q - 8'd1;
          if (down_q == 8'd1) next_state = RINGING;
        end
      end
      default: next_state = IDLE;
    endcase
    // Leaving an alarm event always starts the next one from a clean slate.
    if ((next_state == IDLE) && (state_q != IDLE)) begin
      next_snz  = '0;
      next_down = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      thr_q       <= '0;
      down_q      <= '0;
      snz_q       <= '0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      state_q     <= next_state;
      thr_q       <= next_thr;
      down_q      <= next_down;
      snz_q       <= next_snz;
      alarm       <= (next_state == RINGING);
      alarm_pulse <= (next_state == RINGING) && (state_q != RINGING);
    end
  end

  assign state      = state_q;
  assign snooze_cnt = snz_q;

endmodule

// File: tb/tb_timer_alarm.sv
// Testbench for timer_alarm: directed scenarios followed by a randomized run,
// all outputs compared every cycle against a behavioural model.
module tb_timer_alarm;
  import timer_alarm_pkg::*;

  localparam int SNOOZE_TICKS = 8;
  localparam int MAX_SNOOZE   = 3;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] timer_time;
  logic       set_en;
  logic [7:0] set_value;
  logic       arm;
  logic       ack;
  logic       snooze;
  logic [7:0] stable_time;
  logic       alarm;
  logic       alarm_pulse;
  logic [1:0] state;
  logic [1:0] snooze_cnt;

  always #5 clk = ~clk;

  timer_alarm #(.SNOOZE_TICKS(SNOOZE_TICKS), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .clk        (clk),
    .reset      (reset),
    .timer_time (timer_time),
    .set_en     (set_en),
    .set_value  (set_value),
    .arm        (arm),
    .ack        (ack),
    .snooze     (snooze),
    .stable_time(stable_time),
    .alarm      (alarm),
    .alarm_pulse(alarm_pulse),
    .state      (state),
    .snooze_cnt (snooze_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model. samp_q holds the timer value seen at every clock
  // edge; a value becomes the stable time when it was seen on two edges in a
  // row and differs from the current stable time. The alarm reacts one edge
  // after such an update.
  logic [7:0] samp_q[$];
  logic [7:0] m_stable;
  logic [7:0] m_thr;
  bit         m_tick;
  int         m_state;   // 0 idle, 1 armed, 2 ringing, 3 snoozing
  int         m_snz;
  int         m_left;    // timer increments still to wait while snoozing
  bit         m_alarm;
  bit         m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    samp_q   = {8'd0, 8'd0};
    m_stable = 8'd0;
    m_thr    = 8'd0;
    m_tick   = 1'b0;
    m_state  = 0;
    m_snz    = 0;
    m_left   = 0;
    m_alarm  = 1'b0;
    m_pulse  = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] i_time, input bit i_set, input logic [7:0] i_val,
                            input bit i_arm, input bit i_ack, input bit i_snz);
    int         prev;
    logic [7:0] newest;
    logic [7:0] older;
    prev = m_state;
    if (m_state == 0) begin
      if (i_set) m_thr = i_val;
      if (i_arm) m_state = 1;
    end else if (m_state == 1) begin
      if (m_tick && m_stable == m_thr) m_state = 2;
    end else if (m_state == 2) begin
      if (i_ack) m_state = 0;
      else if (i_snz && m_snz < MAX_SNOOZE) begin
        m_state = 3;
        m_left  = SNOOZE_TICKS;
        m_snz   = m_snz + 1;
      end
    end else begin
      if (i_ack) m_state = 0;
      else if (m_tick) begin
        m_left = m_left - 1;
        if (m_left == 0) m_state = 2;
      end
    end
    if (m_state == 0) begin
      m_snz  = 0;
      m_left = 0;
    end
    m_alarm = (m_state == 2);
    m_pulse = (m_state == 2) && (prev != 2);
    newest = samp_q[samp_q.size()-1];
    older  = samp_q[samp_q.size()-2];
    m_tick = (newest == older) && (older != m_stable);
    if (m_tick) m_stable = older;
    samp_q.push_back(i_time);
    if (samp_q.size() > 4) void'(samp_q.pop_front());
  endtask

  task automatic check_all();
    check("stable_time", stable_time, m_stable);
    check("alarm", alarm, m_alarm);
    check("alarm_pulse", alarm_pulse, m_pulse);
    check("state", state, m_state);
    check("snooze_cnt", snooze_cnt, m_snz);
  endtask

  // driver tasks
  task automatic step();
    logic [7:0] t = timer_time;
    bit         se = set_en;
    logic [7:0] sv = set_value;
    bit         a = arm;
    bit         k = ack;
    bit         s = snooze;
    @(posedge clk);
    model_edge(t, se, sv, a, k, s);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    timer_time = v;
    repeat (n) step();
  endtask

  // Each increment is held three cycles: long enough for one tick each.
  task automatic advance(input int k);
    repeat (k) hold(timer_time + 8'd1, 3);
  endtask

  task automatic load_and_arm(input logic [7:0] v);
    set_en = 1'b1; set_value = v; step();
    set_en = 1'b0; arm = 1'b1; step();
    arm = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; step(); snooze = 1'b0;
  endtask

  initial begin
    logic [7:0] base;
    int         hold_left;

    reset = 1'b1; timer_time = 8'd0; set_en = 1'b0; set_value = 8'd0;
    arm = 1'b0; ack = 1'b0; snooze = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #2;
    check("reset_state", state, 0);
    check("reset_alarm", alarm, 0);
    check("reset_pulse", alarm_pulse, 0);
    check("reset_stable", stable_time, 0);
    check("reset_snz", snooze_cnt, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // threshold 5: ring four cycles after timer_time reaches 5
    step();
    load_and_arm(8'd5);
    check("armed", state, 1);
    for (int v = 1; v <= 4; v++) hold(8'(v), 3);
    timer_time = 8'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("thr5_early", alarm, 0);
    end
    step();
    check("thr5_alarm", alarm, 1);
    check("thr5_pulse", alarm_pulse, 1);
    check("thr5_state", state, 2);
    step();
    check("thr5_pulse_once", alarm_pulse, 0);
    check("thr5_still", alarm, 1);
    pulse_ack();
    check("ack_idle", state, 0);

    // one-cycle glitch through 0x0F must not reach stable_time
    load_and_arm(8'h0F);
    hold(8'h07, 4);
    timer_time = 8'h0F;
    step();
    check("glitch_stable", stable_time == 8'h0F, 0);
    timer_time = 8'h08;
    for (int i = 0; i < 6; i++) begin
      step();
      check("glitch_stable", stable_time == 8'h0F, 0);
      check("glitch_alarm", alarm, 0);
    end
    hold(8'h0F, 4);
    check("glitch_real", state, 2);
    pulse_ack();

    // threshold 0 armed at 200 rings on the 255->0 wrap; ack beats snooze
    set_en = 1'b1; set_value = 8'd0; step(); set_en = 1'b0;
    hold(8'd200, 3);
    arm = 1'b1; step(); arm = 1'b0;
    for (int v = 201; v <= 255; v++) hold(8'(v), 3);
    check("wrap_wait", state, 1);
    timer_time = 8'd0;
    repeat (3) step();
    check("wrap_early", alarm, 0);
    step();
    check("wrap_alarm", alarm, 1);
    check("wrap_pulse", alarm_pulse, 1);
    ack = 1'b1; snooze = 1'b1; step(); ack = 1'b0; snooze = 1'b0;
    check("ack_priority", state, 0);
    check("ack_priority_snz", snooze_cnt, 0);

    // arming while stable_time already equals the threshold must wait
    arm = 1'b1; step(); arm = 1'b0;
    repeat (6) step();
    check("no_level_match", state, 1);
    hold(8'd1, 3);
    hold(8'd0, 4);
    check("fresh_match", state, 2);

    // snooze: eight increments later the alarm rings again
    pulse_snooze();
    check("snooze_state", state, 3);
    check("snooze_cnt1", snooze_cnt, 1);
    snooze = 1'b1;
    advance(7);
    snooze = 1'b0;
    check("snooze_ignored", snooze_cnt, 1);
    check("snooze_waiting", state, 3);
    timer_time = timer_time + 8'd1;
    repeat (3) step();
    check("snooze_not_yet", state, 3);
    step();
    check("resnooze_ring", state, 2);
    check("resnooze_pulse", alarm_pulse, 1);
    check("resnooze_cnt", snooze_cnt, 1);

    // snooze exhaustion
    for (int n = 2; n <= MAX_SNOOZE; n++) begin
      pulse_snooze();
      advance(SNOOZE_TICKS);
      step();
      check("exhaust_ring", state, 2);
      check("exhaust_cnt", snooze_cnt, n);
    end
    pulse_snooze();
    check("exhaust_stay", state, 2);
    check("exhaust_cnt_max", snooze_cnt, 3);
    check("exhaust_no_pulse", alarm_pulse, 0);
    pulse_ack();
    check("exhaust_ack", state, 0);
    check("exhaust_clear", snooze_cnt, 0);

    // asynchronous reset while snoozing
    load_and_arm(8'h40);
    hold(8'h40, 4);
    check("pre_reset_ring", state, 2);
    pulse_snooze();
    repeat (2) step();
    check("pre_reset_snooze", state, 3);
    #2 reset = 1'b0;
    #1;
    check("async_alarm", alarm, 0);
    check("async_state", state, 0);
    check("async_snz", snooze_cnt, 0);
    check("async_stable", stable_time, 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    step();
    check("post_reset_idle", state, 0);
    arm = 1'b1; step(); arm = 1'b0;
    hold(8'd5, 4);
    hold(8'd0, 4);
    check("post_reset_thr0", state, 2);
    pulse_ack();

    // randomized traffic
    base = timer_time;
    hold_left = 0;
    repeat (1500) begin
      if (hold_left == 0) begin
        base = base + 8'd1;
        hold_left = $urandom_range(2, 4);
        timer_time = base;
      end else if ($urandom_range(0, 19) == 0) begin
        timer_time = 8'($urandom);
      end else begin
        timer_time = base;
      end
      hold_left--;
      set_en    = ($urandom_range(0, 3) == 0);
      set_value = base + 8'($urandom_range(1, 10));
      arm       = ($urandom_range(0, 3) == 0);
      ack       = ($urandom_range(0, 39) == 0);
      snooze    = ($urandom_range(0, 5) == 0);
      step();
    end
    set_en = 1'b0; arm = 1'b0; ack = 1'b0; snooze = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
